// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared constants and scan-state type for the 7-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam int         DIG_W   = 4;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [0:0] {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl_if
// Description : Host write bus into the digit bank of the scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_ctrl_if #(
    parameter int IDX_W = 2
);

    logic                       wr_en;
    logic [IDX_W-1:0]           wr_idx;
    logic [seg7_pkg::DIG_W-1:0] wr_val;

    modport master (
        output wr_en,
        output wr_idx,
        output wr_val
    );

    modport slave (
        input wr_en,
        input wr_idx,
        input wr_val
    );

endinterface
`default_nettype wire

// File: rtl/seg7_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_timer
// Description : Terminal-count interval timer; restarts from zero on done.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_timer #(
    parameter int CNT_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic [CNT_W-1:0] i_term,
    output logic                  o_done
);

    logic [CNT_W-1:0] r_count;

    assign o_done = (r_count == i_term);

    always_ff @(posedge clk) begin
        if (rst || i_clr || o_done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed common-anode 7-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int IDX_W        = 2,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            en,
    seg7_scan_ctrl_if.slave      wr_bus,
    output logic [DIG_W-1:0]     dec_val,
    input  wire logic [6:0]      dec_seg,
    output logic [6:0]           seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                 frame_done
);

    localparam int c_cnt_max = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_aw      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [0:0]         c_st_guard = GUARD;
    localparam logic [0:0]         c_st_show  = SHOW;
    localparam logic [IDX_W-1:0]   c_idx_last = IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_cnt_w-1:0] c_term_g   = c_cnt_w'(GUARD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_term_s   = c_cnt_w'(REFRESH_DIV - 1);

    logic [DIG_W-1:0]   r_bank [NUM_DIGITS];
    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_idx;

    logic               w_wr_ok;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [c_cnt_w-1:0] w_term;
    logic               w_done;

    assign w_wr_ok   = wr_bus.wr_en &&
                       ({1'b0, wr_bus.wr_idx} < (IDX_W + 1)'(NUM_DIGITS));
    assign w_idx_nxt = (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
    assign w_term    = (r_state == c_st_show) ? c_term_s : c_term_g;

    // One counter serves both intervals; the terminal value follows the state.
    seg7_scan_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (!en),
        .i_term (w_term),
        .o_done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_bank[i] <= '0;
            end
            r_state    <= c_st_guard;
            r_idx      <= '0;
            dec_val    <= '0;
            seg        <= SEG_OFF;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_bank[wr_bus.wr_idx[c_aw-1:0]] <= wr_bus.wr_val;
            end

            seg        <= SEG_OFF;
            an         <= '1;
            frame_done <= 1'b0;

            // dec_val is only reloaded on GUARD entry, reading the pre-edge bank,
            // so a write to the lit digit appears on its next visit.
            if (!en) begin
                r_state <= c_st_guard;
                dec_val <= r_bank[r_idx[c_aw-1:0]];
            end else if (r_state == c_st_show) begin
                an  <= ~(NUM_DIGITS'(1) << r_idx);
                seg <= dec_seg;
                if (w_done) begin
                    r_state    <= c_st_guard;
                    r_idx      <= w_idx_nxt;
                    dec_val    <= r_bank[w_idx_nxt[c_aw-1:0]];
                    frame_done <= (r_idx == c_idx_last);
                end
            end else if (w_done) begin
                r_state <= c_st_show;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl with a slot-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int R = 4;
    localparam int G = 2;
    localparam int P = G + R;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] dec_val;
    logic [6:0] dec_seg;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_done;

    int n_chk  = 0;
    int n_pass = 0;
    bit mdl_on = 1'b0;

    seg7_scan_ctrl_if #(.IDX_W(3)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .IDX_W        (3),
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_bus     (bus),
        .dec_val    (dec_val),
        .dec_seg    (dec_seg),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;
            4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
            4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;
            4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;
            4'hE: seg_of = 7'h06;  default: seg_of = 7'h0E;
        endcase
    endfunction

    assign dec_seg = seg_of(dec_val);

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: s counts enabled edges since the last restart; each digit owns a
    // slot of P edges, dark for the first G and lit for the remaining R.
    logic [3:0] m_bank [N];
    logic [3:0] m_bpre [N];
    logic [3:0] m_dec;
    int         m_s, m_idx0, m_pos, m_dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_fd;

    always @(posedge clk) begin
        m_bpre = m_bank;
        if (rst) begin
            for (int i = 0; i < N; i++) m_bank[i] = 4'h0;
            m_s = 0; m_idx0 = 0; m_dec = 4'h0;
            e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
        end else begin
            if (bus.wr_en && int'(bus.wr_idx) < N) m_bank[int'(bus.wr_idx)] = bus.wr_val;
            e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
            if (!en) begin
                m_idx0 = (m_idx0 + m_s / P) % N;
                m_s    = 0;
                m_dec  = m_bpre[m_idx0];
            end else begin
                m_s++;
                m_pos = (m_s - 1) % P;
                m_dig = (m_idx0 + (m_s - 1) / P) % N;
                if (m_pos >= G) begin
                    e_an  = ~(4'b0001 << m_dig);
                    e_seg = seg_of(m_dec);
                end
                if (m_pos == P - 1) begin
                    e_fd  = (m_dig == N - 1);
                    m_dec = m_bpre[(m_idx0 + m_s / P) % N];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("mdl_an", int'(an), int'(e_an));
            chk("mdl_seg", int'(seg), int'(e_seg));
            chk("mdl_dec_val", int'(dec_val), int'(m_dec));
            chk("mdl_frame_done", int'(frame_done), int'(e_fd));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] v, input bit want_eq, input string name);
        int n = 0;
        while (((an == v) != want_eq) && n < 64) begin
            tick();
            n++;
        end
        chk(name, int'(an == v), int'(want_eq));
    endtask

    task automatic wr(input logic [2:0] idx, input logic [3:0] val);
        bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_val = val;
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] seq [12];
        logic [3:0] exp_seq [12];
        int fd_cnt, fd_first;

        rst = 1'b1; en = 1'b0;
        bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_val = '0;
        tick();
        mdl_on = 1'b1;
        tick();
        chk("rst_an", int'(an), 'hF);
        chk("rst_seg", int'(seg), 'h7F);
        chk("rst_dec_val", int'(dec_val), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        // Empty bank: guard 2, digit 0 lit 4, guard 2, digit 1 lit.
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            seq[i] = an;
            if (i == 2) chk("empty_seg0", int'(seg), 'h40);
        end
        exp_seq = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD};
        for (int i = 0; i < 12; i++) chk($sformatf("startup_an[%0d]", i), int'(seq[i]), int'(exp_seq[i]));

        wr(3'd3, 4'd9); wr(3'd2, 4'd7); wr(3'd1, 4'd5); wr(3'd0, 4'd1);

        // Frame cadence: pulses exactly 24 cycles apart, while digit 3 is lit.
        fd_cnt = 0;
        while (!frame_done && fd_cnt < 64) begin tick(); fd_cnt++; end
        chk("fd_seen", int'(frame_done), 1);
        chk("fd_an", int'(an), 'h7);
        fd_cnt = 0; fd_first = -1;
        for (int i = 1; i <= 48; i++) begin
            tick();
            if (frame_done) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = i;
            end
        end
        chk("fd_count", fd_cnt, 2);
        chk("fd_period", fd_first, 24);

        wait_an(4'hE, 1'b1, "wait_dig0");
        chk("dig0_dec", int'(dec_val), 1);
        chk("dig0_seg", int'(seg), 'h79);
        wait_an(4'hB, 1'b1, "wait_dig2");
        chk("dig2_dec", int'(dec_val), 7);
        chk("dig2_seg", int'(seg), 'h78);
        wait_an(4'h7, 1'b1, "wait_dig3");
        chk("dig3_dec", int'(dec_val), 9);
        chk("dig3_seg", int'(seg), 'h10);

        // Write to the lit digit, then an out-of-range index that aliases to it.
        wait_an(4'hD, 1'b1, "wait_dig1");
        chk("dig1_dec", int'(dec_val), 5);
        wr(3'd1, 4'd8);
        chk("dig1_hold_a", int'(dec_val), 5);
        wr(3'd5, 4'd3);
        chk("dig1_hold_b", int'(dec_val), 5);
        wait_an(4'hD, 1'b0, "leave_dig1");
        wait_an(4'hD, 1'b1, "revisit_dig1");
        chk("dig1_new_dec", int'(dec_val), 8);
        chk("dig1_new_seg", int'(seg), 'h00);

        // Drop en mid-show of digit 2, then resume on the same digit.
        wait_an(4'hB, 1'b1, "wait_dig2_en");
        en = 1'b0;
        tick();
        chk("en0_an", int'(an), 'hF);
        chk("en0_seg", int'(seg), 'h7F);
        tick(); tick();
        en = 1'b1;
        tick(); chk("en1_guard_a", int'(an), 'hF);
        tick(); chk("en1_guard_b", int'(an), 'hF);
        tick(); chk("en1_dig2", int'(an), 'hB);
        chk("en1_dec", int'(dec_val), 7);

        // Reset just before digit 3's last lit edge: no frame_done may escape.
        wait_an(4'h7, 1'b1, "wait_dig3_rst");
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_fd", int'(frame_done), 0);
        chk("rst_mid_an", int'(an), 'hF);
        chk("rst_mid_seg", int'(seg), 'h7F);
        chk("rst_mid_dec", int'(dec_val), 0);
        rst = 1'b0;
        wait_an(4'hB, 1'b1, "wait_dig2_clr");
        chk("clr_dec", int'(dec_val), 0);
        chk("clr_seg", int'(seg), 'h40);

        tick();
        mdl_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
